// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM fade sequencer and its LED-timing helpers.
// Holds the duty width, the fade state encoding and a counter-width helper.
package pwm_pkg;

    localparam int DUTY_W = 8;

    typedef enum logic [1:0] {
        RAMP_UP   = 2'd0,
        HOLD_HI   = 2'd1,
        RAMP_DOWN = 2'd2,
        HOLD_LO   = 2'd3
    } fade_state_e;

    // Width needed to count 0..n-1, never narrower than one bit.
    function automatic int unsigned min1_clog2(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pwm_tick_div.sv
// Free-running prescaler that emits a one-cycle tick every DIV enabled cycles.
// Reusable by any LED timing block that needs a slow strobe in the clk domain.
module pwm_tick_div
    import pwm_pkg::*;
#(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned       CNT_W = min1_clog2(DIV);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_last;

    assign w_last = (r_cnt == LAST);

    // NOTE: state uses non-blocking assignments so every register samples
    // pre-edge values; the async reset sits in the sensitivity list.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            if (w_last) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // A clear in the same cycle swallows the tick.
    assign tick = en & w_last & ~clr;

endmodule

// File: rtl/pwm_fade_ctrl.sv
// Breathing-profile duty sequencer: ramps duty up, holds, ramps down, holds.
// Output feeds the PWM generator's duty input directly in the same clk domain.
module pwm_fade_ctrl
    import pwm_pkg::*;
#(
    parameter int unsigned       STEP_DIV   = 195312,
    parameter int unsigned       HOLD_TICKS = 64,
    parameter logic [DUTY_W-1:0] DUTY_MIN   = 8'h00,
    parameter logic [DUTY_W-1:0] DUTY_MAX   = 8'hFF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              restart,
    input  logic [DUTY_W-1:0] step_in,
    output logic [DUTY_W-1:0] duty_cycle,
    output logic              dir_up,
    output logic              at_limit
);

    localparam bit                NO_HOLD   = (HOLD_TICKS == 0);
    localparam int unsigned       HOLD_W    = min1_clog2(HOLD_TICKS + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(NO_HOLD ? 0 : HOLD_TICKS - 1);

    logic              w_tick;
    fade_state_e       r_state;
    logic [DUTY_W-1:0] r_duty;
    logic              r_dir_up;
    logic              r_at_limit;
    logic [HOLD_W-1:0] r_hold_cnt;

    logic [DUTY_W:0]   w_up_sum;
    logic [DUTY_W:0]   w_dn_thr;
    logic [DUTY_W-1:0] w_dn_diff;
    logic              w_up_sat;
    logic              w_dn_sat;
    logic              w_step_zero;
    logic              w_hold_done;

    pwm_tick_div #(
        .DIV (STEP_DIV)
    ) u_tick_div (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (enable),
        .clr   (restart),
        .tick  (w_tick)
    );

    // Nine-bit arithmetic so a large step saturates instead of wrapping.
    assign w_up_sum    = {1'b0, r_duty} + {1'b0, step_in};
    assign w_dn_thr    = {1'b0, DUTY_MIN} + {1'b0, step_in};
    assign w_dn_diff   = r_duty - step_in;
    assign w_up_sat    = (w_up_sum >= {1'b0, DUTY_MAX});
    assign w_dn_sat    = ({1'b0, r_duty} <= w_dn_thr);
    assign w_step_zero = (step_in == '0);
    assign w_hold_done = (r_hold_cnt == HOLD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= RAMP_UP;
            r_duty     <= DUTY_MIN;
            r_dir_up   <= 1'b1;
            r_at_limit <= 1'b0;
            r_hold_cnt <= '0;
        end else if (restart) begin
            r_state    <= RAMP_UP;
            r_duty     <= DUTY_MIN;
            r_dir_up   <= 1'b1;
            r_at_limit <= 1'b0;
            r_hold_cnt <= '0;
        end else if (w_tick) begin
            case (r_state)
                RAMP_UP: begin
                    // A zero step freezes the ramp rather than forcing a bound.
                    if (!w_step_zero) begin
                        if (w_up_sat) begin
                            r_duty <= DUTY_MAX;
                            if (NO_HOLD) begin
                                r_state  <= RAMP_DOWN;
                                r_dir_up <= 1'b0;
                            end else begin
                                r_state    <= HOLD_HI;
                                r_at_limit <= 1'b1;
                            end
                        end else begin
                            r_duty <= w_up_sum[DUTY_W-1:0];
                        end
                    end
                end
                HOLD_HI: begin
                    if (w_hold_done) begin
                        r_hold_cnt <= '0;
                        r_state    <= RAMP_DOWN;
                        r_dir_up   <= 1'b0;
                        r_at_limit <= 1'b0;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
                    end
                end
                RAMP_DOWN: begin
                    if (!w_step_zero) begin
                        if (w_dn_sat) begin
                            r_duty <= DUTY_MIN;
                            if (NO_HOLD) begin
                                r_state  <= RAMP_UP;
                                r_dir_up <= 1'b1;
                            end else begin
                                r_state    <= HOLD_LO;
                                r_at_limit <= 1'b1;
                            end
                        end else begin
                            r_duty <= w_dn_diff;
                        end
                    end
                end
                HOLD_LO: begin
                    if (w_hold_done) begin
                        r_hold_cnt <= '0;
                        r_state    <= RAMP_UP;
                        r_dir_up   <= 1'b1;
                        r_at_limit <= 1'b0;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
                    end
                end
                default: begin
                    r_state    <= RAMP_UP;
                    r_duty     <= DUTY_MIN;
                    r_dir_up   <= 1'b1;
                    r_at_limit <= 1'b0;
                    r_hold_cnt <= '0;
                end
            endcase
        end
    end

    assign duty_cycle = r_duty;
    assign dir_up     = r_dir_up;
    assign at_limit   = r_at_limit;

endmodule

// File: doc/pwm_fade_ctrl.md
# pwm_fade_ctrl

Duty-cycle sequencer that drives the 8-bit `duty_cycle` input of the PWM generator on the DE10-Lite PWM design. It produces a repeating triangular "breathing" profile: ramp up, hold at maximum, ramp down, hold at minimum. Step size and pause/restart are runtime controls. It runs in the same 50 MHz domain as the PWM generator, and its output connects directly to that generator with no retiming.

## Interface
- `STEP_DIV`, default 195312: clock cycles per step tick. Valid range ≥ 1. At 50 MHz this gives about 256 ticks/s.
- `HOLD_TICKS`, default 64: ticks spent at each extreme. A value of 0 skips the hold.
- `DUTY_MIN`, default 8'h00: lower duty bound. Constraint: `DUTY_MIN < DUTY_MAX`.
- `DUTY_MAX`, default 8'hFF: upper duty bound.
- `clk` in 1: 50 MHz system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `enable` in 1: 1 = run; 0 = freeze prescaler, hold counter, state and duty.
- `restart` in 1: single-cycle synchronous pulse; restarts the profile from `DUTY_MIN`.
- `step_in` in 8: duty increment/decrement applied per tick in ramp states.
- `duty_cycle` out 8: registered duty value to the PWM generator.
- `dir_up` out 1: 1 in RAMP_UP/HOLD_HI, 0 in RAMP_DOWN/HOLD_LO.
- `at_limit` out 1: 1 while in HOLD_HI or HOLD_LO.

## Operation
- Reset values (async on `rst_n` low):
  - state = RAMP_UP, `duty_cycle` = `DUTY_MIN`, `dir_up` = 1, `at_limit` = 0.
  - Prescaler = 0, hold counter = 0.
- Prescaler:
  - Increments each cycle while `enable` = 1.
  - `tick` is asserted in the cycle where the count equals `STEP_DIV-1`; the count then wraps to 0.
  - With `STEP_DIV` = 1, `tick` is asserted every enabled cycle.
- `step_in` is sampled only in tick cycles. The sum or difference is computed 9 bits wide, so there is no wrap-around.
- State transitions, on tick only:
  - RAMP_UP: if `duty + step_in >= DUTY_MAX`, set duty = `DUTY_MAX` and go to HOLD_HI (or directly to RAMP_DOWN if `HOLD_TICKS` = 0). Otherwise duty += `step_in`.
  - HOLD_HI: hold_cnt++. When hold_cnt reaches `HOLD_TICKS-1`, clear hold_cnt and go to RAMP_DOWN. Duty is unchanged.
  - RAMP_DOWN: if `duty <= DUTY_MIN + step_in`, set duty = `DUTY_MIN` and go to HOLD_LO (or directly to RAMP_UP if `HOLD_TICKS` = 0). Otherwise duty −= `step_in`.
  - HOLD_LO: mirror of HOLD_HI; exits to RAMP_UP.
- `step_in` = 0: duty stays frozen in ramp states and the state does not advance. Hold states still count normally.
- `restart` has highest priority and acts regardless of `enable` or `tick`:
  - state = RAMP_UP, duty = `DUTY_MIN`.
  - Prescaler = 0, hold_cnt = 0.
  - The restart cycle is not itself counted toward the next tick.
- `enable` low: all registers hold. Resuming continues from the stored prescaler count; the phase is not reset.
- `dir_up` and `at_limit` are decoded from the registered state and update in the same cycle as the state register.

## Timing
- Latency: a tick in cycle N updates `duty_cycle`, state, `dir_up` and `at_limit` at the clock edge ending cycle N, so they are visible in cycle N+1.
- After reset release with `enable` = 1, the first tick occurs on the `STEP_DIV`-th rising edge.
- `duty_cycle` changes at most once per `STEP_DIV` cycles, and only by `step_in` or by saturation to a bound.
- `restart` coinciding with `tick`: restart wins and the tick is discarded.
- Reset asserted mid-ramp: outputs return to reset values immediately (asynchronously). Operation resumes on the first edge after `rst_n` deasserts.
- Tick in the final hold cycle: the state changes and the hold counter clears in the same edge. There is no extra idle tick.

## Structure
- Shared package `pwm_pkg`:
  - `DUTY_W` = 8.
  - State encoding constants RAMP_UP/HOLD_HI/RAMP_DOWN/HOLD_LO (2-bit).
- Sub-module `pwm_tick_div`: parameter `DIV`; ports `clk`, `rst_n`, `en`, `clr`, `tick`.
  - The counter is sized by `$clog2(DIV)`, with a minimum width of 1.
  - It is reusable for other LED timing blocks.
- Top level holds the FSM, the saturating 9-bit add/subtract, and the hold counter. The hold counter width is `$clog2(HOLD_TICKS+1)`.

## Test plan
Bench parameters: `STEP_DIV` = 4, `HOLD_TICKS` = 2, `DUTY_MIN` = 00, `DUTY_MAX` = FF. The PWM generator is instantiated downstream of this block.
- Full cycle, `step_in` = 40, `enable` = 1 from reset:
  - Duty sequence 00→40→80→C0→FF, changing every 4 cycles.
  - `at_limit` is high for 8 cycles.
  - Then BF→7F→3F→00 with `dir_up` = 0, then `at_limit` high, then the ramp repeats.
- Pause: drop `enable` for 20 cycles mid-ramp at duty = 80 → duty, state and prescaler are frozen. Resume → next tick after the remaining prescaler count.
- `restart` pulse while in RAMP_DOWN at duty = 7F, coinciding with a tick → next cycle duty = 00, `dir_up` = 1, and the first tick 4 cycles later gives duty = 40.
- `step_in` = 0 in RAMP_UP at duty = 40 → duty stays 40 across 10 ticks. Then `step_in` = FF → duty saturates to FF and enters HOLD_HI.
- `HOLD_TICKS` = 0 variant, `step_in` = 80 → 00→80→FF→7F→00. `at_limit` is never asserted.
- Async reset asserted mid-cycle while in HOLD_HI → `duty_cycle` = 00 and `dir_up` = 1 before the next clock edge. The PWM output is low through the following period.
